// File: rtl/tama_update_scheduler.sv
// tama_update_scheduler: arbitrates player actions and decay sweeps into one stat-update command stream
module tama_update_scheduler #(
   parameter logic [23:0] TICK_COUNT = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] btn,
   input  logic [7:0] rnd,
   input  logic       upd_ready,
   output logic       upd_valid,
   output logic [2:0] upd_sel,
   output logic       upd_inc,
   output logic [1:0] upd_amt,
   output logic       busy,
   output logic       tick,
   output logic       tick_drop
);
   typedef enum logic [1:0] {IDLE, ACTION, DECAY} state_t;
   state_t      state;
   logic [23:0] cnt;
   logic [5:0]  btn_q, pend, rise, clr;
   logic        decay_pend, start, xfer;
   logic [2:0]  last_grant, gnt;

   function automatic logic [2:0] wrap6(input logic [2:0] a, input logic [2:0] k);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, k};
      return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
   endfunction

   assign tick  = cnt == TICK_COUNT - 24'd1;
   assign rise  = btn & ~btn_q;
   assign xfer  = upd_valid & upd_ready;
   assign start = (state == IDLE) & decay_pend;
   assign clr   = (state == ACTION && xfer) ? 6'd1 << upd_sel : 6'd0;

   // round-robin pick: the nearest pending bit above last_grant wins
   always_comb begin
      gnt = last_grant;
      for (int k = 6; k >= 1; k--)
         if (pend[wrap6(last_grant, 3'(k))]) gnt = wrap6(last_grant, 3'(k));
   end

   // prescaler, request capture and tick-overrun tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         btn_q      <= '0;
         pend       <= '0;
         decay_pend <= 1'b0;
         tick_drop  <= 1'b0;
      end else begin
         cnt        <= tick ? 24'd0 : cnt + 24'd1;
         btn_q      <= btn;
         pend       <= (pend & ~clr) | rise;
         decay_pend <= tick | (decay_pend & ~start);
         tick_drop  <= tick_drop | (tick & decay_pend & ~start);
      end
   end

   // command sequencer: decay sweeps take priority, actions one at a time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         upd_valid  <= 1'b0;
         upd_sel    <= 3'd0;
         upd_inc    <= 1'b0;
         upd_amt    <= 2'd0;
         busy       <= 1'b0;
         last_grant <= 3'd5;
      end else begin
         case (state)
            IDLE: begin
               if (decay_pend) begin
                  state     <= DECAY;
                  busy      <= 1'b1;
                  upd_valid <= 1'b1;
                  upd_sel   <= 3'd0;
                  upd_inc   <= 1'b0;
                  upd_amt   <= rnd[0] ? 2'd2 : 2'd1;
               end else if (|pend) begin
                  state      <= ACTION;
                  busy       <= 1'b1;
                  upd_valid  <= 1'b1;
                  upd_sel    <= gnt;
                  upd_inc    <= 1'b1;
                  upd_amt    <= 2'd3;
                  last_grant <= gnt;
               end
            end
            ACTION: begin
               if (xfer) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  upd_valid <= 1'b0;
               end
            end
            DECAY: begin
               if (xfer && upd_sel == 3'd5) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  upd_valid <= 1'b0;
               end else if (xfer) begin
                  upd_sel <= upd_sel + 3'd1;
                  upd_amt <= rnd[0] ? 2'd2 : 2'd1;
               end
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               upd_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
